// File: rtl/spi_dep_pkg.sv
// Shared types for the spi_dep host-side master: FSM state encoding and the
// opcode map of the spi_dep slave register file.
package spi_dep_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] OP_INIT     = 8'h10;
  localparam logic [7:0] OP_STOP     = 8'h11;
  localparam logic [7:0] OP_CALIB    = 8'h12;
  localparam logic [7:0] OP_CH_LIMIT = 8'h13;
  localparam logic [7:0] OP_VALID_TX = 8'hAA;

  function automatic logic [15:0] swap_bytes(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/spi_dep_sck_gen.sv
// SCK generator: divides clk_i by CLK_DIV per half-period while enabled and
// emits single-cycle rise/fall strobes coincident with the SCK toggle.
module spi_dep_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic en,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  assign wrap     = en && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign sck_rise = wrap && !sck;
  assign sck_fall = wrap && sck;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_dep_master.sv
// SPI mode-0 master for the spi_dep slave: one framed word per start request.
// Define SPI_DEP_MASTER_BYTE_SWAP_EN to send byte 0 first and unswap the reply.
module spi_dep_master
  import spi_dep_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int CLK_DIV   = 4,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int CS_GAP    = 2
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic                 start_i,
  input  logic [WORD_SIZE-1:0] data_tx_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [WORD_SIZE-1:0] data_rx_o,
  output logic                 spi_sck_o,
  output logic                 spi_sdo_o,
  input  logic                 spi_sdi_i,
  output logic                 spi_cs_o
);

  localparam int BIT_W = $clog2(WORD_SIZE + 1);
  localparam int CMAX  = (CS_SETUP > CS_HOLD) ?
                         ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                         ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
  localparam int CNT_W = $clog2(CMAX + 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [WORD_SIZE-1:0] tx_sr;
  logic [WORD_SIZE-1:0] rx_sr;
  logic [WORD_SIZE-1:0] tx_load;
  logic [WORD_SIZE-1:0] rx_word;
  logic                 sck_rise;
  logic                 sck_fall;
  logic                 last_bit_done;

`ifdef SPI_DEP_MASTER_BYTE_SWAP_EN
  if (WORD_SIZE != 16) begin : g_bad_width
    $error("spi_dep_master: byte swap needs WORD_SIZE=16");
  end
  assign tx_load = swap_bytes(data_tx_i);
  assign rx_word = swap_bytes(rx_sr);
`else
  assign tx_load = data_tx_i;
  assign rx_word = rx_sr;
`endif

  assign last_bit_done = (bit_cnt == BIT_W'(WORD_SIZE));

  spi_dep_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .en       (state == S_SHIFT),
    .sck      (spi_sck_o),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  // Shift registers carry only data; the FSM decides when they move.
  always_ff @(posedge clk_i) begin
    if (state == S_IDLE && start_i)
      tx_sr <= tx_load;
    else if (state == S_SHIFT && sck_fall && !last_bit_done)
      tx_sr <= tx_sr << 1;
    if (state == S_SHIFT && sck_rise)
      rx_sr <= {rx_sr[WORD_SIZE-2:0], spi_sdi_i};
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      data_rx_o <= '0;
      spi_sdo_o <= 1'b0;
      spi_cs_o  <= 1'b1;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state     <= S_SETUP;
            cnt       <= '0;
            busy_o    <= 1'b1;
            spi_cs_o  <= 1'b0;
            spi_sdo_o <= tx_load[WORD_SIZE-1];
          end
        end
        S_SETUP: begin
          if (cnt == CNT_W'(CS_SETUP - 1)) begin
            state   <= S_SHIFT;
            bit_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (sck_rise)
            bit_cnt <= bit_cnt + 1'b1;
          // The fall after the final rise ends the frame instead of shifting.
          if (sck_fall) begin
            if (last_bit_done) begin
              state <= S_HOLD;
              cnt   <= '0;
            end else begin
              spi_sdo_o <= tx_sr[WORD_SIZE-2];
            end
          end
        end
        S_HOLD: begin
          if (cnt == CNT_W'(CS_HOLD - 1)) begin
            spi_cs_o  <= 1'b1;
            done_o    <= 1'b1;
            data_rx_o <= rx_word;
            cnt       <= '0;
            if (CS_GAP == 0) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= S_GAP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == CNT_W'(CS_GAP - 1)) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_dep_master.sv
// Directed bench for spi_dep_master: loopback, slave reply, ignored start,
// mid-frame reset and back-to-back framing (byte-swap build: swap scenario).
module tb_spi_dep_master;

`ifdef SPI_DEP_MASTER_BYTE_SWAP_EN
  localparam int TB_DIV = 1;
`else
  localparam int TB_DIV = 4;
`endif
  localparam int EXP_LOW = 2 + 2 * 16 * TB_DIV + 2;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] data_tx = '0;
  logic        busy, done, sck, sdo, sdi, cs;
  logic [15:0] data_rx;

  logic        loop_en = 1'b1;
  logic [15:0] reply = '0;
  logic        mon_clr = 1'b0;

  int          rise_cnt, done_cnt, lo_run, hi_run, last_low, n_falls;
  int          gaps [8];
  logic [15:0] tx_seen;
  logic [3:0]  slv_bit;
  logic        prev_sck;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_dep_master #(
    .WORD_SIZE(16), .CLK_DIV(TB_DIV), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(2)
  ) dut (
    .clk_i     (clk),
    .nreset_i  (nreset),
    .start_i   (start),
    .data_tx_i (data_tx),
    .busy_o    (busy),
    .done_o    (done),
    .data_rx_o (data_rx),
    .spi_sck_o (sck),
    .spi_sdo_o (sdo),
    .spi_sdi_i (sdi),
    .spi_cs_o  (cs)
  );

  // Slave model: presents reply MSB first, advancing after each SCK fall.
  assign sdi = loop_en ? sdo : reply[slv_bit];

  always @(negedge clk) begin
    if (mon_clr) begin
      rise_cnt <= 0; done_cnt <= 0; tx_seen <= '0; lo_run <= 0; hi_run <= 0;
      last_low <= 0; n_falls <= 0; slv_bit <= 4'd15; prev_sck <= 1'b0;
    end else begin
      prev_sck <= sck;
      if (sck && !prev_sck) begin
        rise_cnt <= rise_cnt + 1;
        tx_seen  <= {tx_seen[14:0], sdo};
      end
      if (cs) slv_bit <= 4'd15;
      else if (!sck && prev_sck && slv_bit != 4'd0) slv_bit <= slv_bit - 4'd1;
      if (done) done_cnt <= done_cnt + 1;
      if (cs) begin
        hi_run <= hi_run + 1;
        lo_run <= 0;
        if (lo_run > 0) last_low <= lo_run;
      end else begin
        lo_run <= lo_run + 1;
        hi_run <= 0;
        if (hi_run > 0) begin
          if (n_falls < 8) gaps[n_falls] <= hi_run;
          n_falls <= n_falls + 1;
        end
      end
    end
  end

  task automatic clear_mon();
    @(negedge clk); #1 mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    @(negedge clk);
    start = 1'b1; data_tx = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_cnt < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    n_cmp++;
    if (done_cnt < n) begin
      n_err++;
      $display("FAIL wait_done: done count %0d, required %0d within %0d cycles", done_cnt, n, budget);
    end
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b required 0", done); end
    n_cmp++; if (data_rx !== 16'h0000) begin n_err++; $display("FAIL reset_rx: got %h required 0000", data_rx); end
    n_cmp++; if (sck !== 1'b0) begin n_err++; $display("FAIL reset_sck: got %b required 0", sck); end
    n_cmp++; if (sdo !== 1'b0) begin n_err++; $display("FAIL reset_sdo: got %b required 0", sdo); end
    n_cmp++; if (cs !== 1'b1) begin n_err++; $display("FAIL reset_cs: got %b required 1", cs); end
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_loopback();
    loop_en = 1'b1;
    clear_mon();
    send(16'h1001);
    wait_done(1, 1000);
    settle();
    n_cmp++; if (last_low !== EXP_LOW) begin n_err++; $display("FAIL loop_cs_low: got %0d required %0d", last_low, EXP_LOW); end
    n_cmp++; if (rise_cnt !== 16) begin n_err++; $display("FAIL loop_rises: got %0d required 16", rise_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL loop_dones: got %0d required 1", done_cnt); end
    n_cmp++; if (data_rx !== 16'h1001) begin n_err++; $display("FAIL loop_rx: got %h required 1001", data_rx); end
    n_cmp++; if (tx_seen !== 16'h1001) begin n_err++; $display("FAIL loop_wire: got %h required 1001", tx_seen); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL loop_busy_end: got %b required 0", busy); end
  endtask

  task automatic test_slave_reply();
    loop_en = 1'b0; reply = 16'hA55A;
    clear_mon();
    send(16'h1301);
    wait_done(1, 1000);
    settle();
    n_cmp++; if (tx_seen !== 16'h1301) begin n_err++; $display("FAIL reply_wire: got %h required 1301", tx_seen); end
    n_cmp++; if (data_rx !== 16'hA55A) begin n_err++; $display("FAIL reply_rx: got %h required a55a", data_rx); end
    n_cmp++; if (rise_cnt !== 16) begin n_err++; $display("FAIL reply_rises: got %0d required 16", rise_cnt); end
  endtask

  task automatic test_ignore_start();
    loop_en = 1'b0; reply = 16'h3C3C;
    clear_mon();
    send(16'h1301);
    repeat (9) @(negedge clk);
    start = 1'b1; data_tx = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (400 * TB_DIV) @(negedge clk);
    #1;
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL ignore_dones: got %0d required 1", done_cnt); end
    n_cmp++; if (n_falls !== 1) begin n_err++; $display("FAIL ignore_frames: got %0d required 1", n_falls); end
    n_cmp++; if (data_rx !== 16'h3C3C) begin n_err++; $display("FAIL ignore_rx: got %h required 3c3c", data_rx); end
    n_cmp++; if (tx_seen !== 16'h1301) begin n_err++; $display("FAIL ignore_wire: got %h required 1301", tx_seen); end
  endtask

  task automatic test_reset_mid();
    int k;
    loop_en = 1'b1;
    clear_mon();
    send(16'h5AF0);
    k = 0;
    while (rise_cnt < 8 && k < 1000) begin
      @(negedge clk); #1;
      k++;
    end
    n_cmp++;
    if (rise_cnt < 8) begin n_err++; $display("FAIL mid_reach_bit7: rises %0d required 8", rise_cnt); end
    #2 nreset = 1'b0;
    #1;
    n_cmp++; if (cs !== 1'b1) begin n_err++; $display("FAIL mid_cs: got %b required 1", cs); end
    n_cmp++; if (sck !== 1'b0) begin n_err++; $display("FAIL mid_sck: got %b required 0", sck); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b required 0", busy); end
    n_cmp++; if (data_rx !== 16'h0000) begin n_err++; $display("FAIL mid_rx: got %h required 0000", data_rx); end
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL mid_no_done: got %0d required 0", done_cnt); end
    clear_mon();
    send(16'hBEEF);
    wait_done(1, 1000);
    settle();
    n_cmp++; if (data_rx !== 16'hBEEF) begin n_err++; $display("FAIL mid_next_rx: got %h required beef", data_rx); end
    n_cmp++; if (last_low !== EXP_LOW) begin n_err++; $display("FAIL mid_next_cs_low: got %0d required %0d", last_low, EXP_LOW); end
    n_cmp++; if (rise_cnt !== 16) begin n_err++; $display("FAIL mid_next_rises: got %0d required 16", rise_cnt); end
  endtask

  task automatic test_back_to_back();
    loop_en = 1'b1;
    clear_mon();
    @(negedge clk);
    start = 1'b1; data_tx = 16'h00FF;
    wait_done(3, 3000);
    start = 1'b0;
    repeat (300 * TB_DIV) @(negedge clk);
    #1;
    n_cmp++; if (n_falls !== 3) begin n_err++; $display("FAIL b2b_frames: got %0d required 3", n_falls); end
    n_cmp++; if (done_cnt !== 3) begin n_err++; $display("FAIL b2b_dones: got %0d required 3", done_cnt); end
    n_cmp++; if (gaps[1] !== 3) begin n_err++; $display("FAIL b2b_gap1: got %0d required 3", gaps[1]); end
    n_cmp++; if (gaps[2] !== 3) begin n_err++; $display("FAIL b2b_gap2: got %0d required 3", gaps[2]); end
    n_cmp++; if (data_rx !== 16'h00FF) begin n_err++; $display("FAIL b2b_rx: got %h required 00ff", data_rx); end
  endtask

  task automatic test_byte_swap();
    loop_en = 1'b1;
    clear_mon();
    send(16'h12AB);
    wait_done(1, 1000);
    settle();
    n_cmp++; if (tx_seen !== 16'hAB12) begin n_err++; $display("FAIL swap_wire: got %h required ab12", tx_seen); end
    n_cmp++; if (data_rx !== 16'h12AB) begin n_err++; $display("FAIL swap_rx: got %h required 12ab", data_rx); end
    n_cmp++; if (rise_cnt !== 16) begin n_err++; $display("FAIL swap_rises: got %0d required 16", rise_cnt); end
    n_cmp++; if (last_low !== EXP_LOW) begin n_err++; $display("FAIL swap_cs_low: got %0d required %0d", last_low, EXP_LOW); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL swap_dones: got %0d required 1", done_cnt); end
  endtask

  initial begin
    test_reset();
`ifdef SPI_DEP_MASTER_BYTE_SWAP_EN
    test_byte_swap();
`else
    test_loopback();
    test_slave_reply();
    test_ignore_start();
    test_reset_mid();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
